tug_match_controller: RTL and testbench
=======================================

// Module: tug_match_controller
// PURPOSE
//  Sequences a best-of-N tug-of-war match around the 9-light playfield and its pull inputs.
//  Detects round wins from the edge lights and the debounced pulls, and keeps per-player scores.
//  Holds the result for a fixed display time, then pulses a playfield clear and re-arms play.
//  Sits between the userInput pull pulses and the light chain; its field_reset ORs into the light reset.
// PARAMETERS
//  WIN_ROUNDS   3           rounds needed to win the match (1..7)
//  HOLD_CYCLES  50_000_000  cycles the round result is held before the field clears (>=1)
// PORTS
//  clk           in   1  system clock (CLOCK_50)
//  reset         in   1  asynchronous, active-high; one clock, no other clock domain
//  start         in   1  single-cycle pulse: begin match (IDLE) or restart match (DONE)
//  L             in   1  left pull pulse, one cycle per press
//  R             in   1  right pull pulse, one cycle per press
//  left_edge     in   1  leftmost light lit (LEDR[9])
//  right_edge    in   1  rightmost light lit (LEDR[1])
//  pull_en       out  1  gates L/R into the light chain; 1 only in PLAY
//  field_reset   out  1  forces the light chain to its centre-lit reset state
//  round_winner  out  2  player_t: 00 none, 01 left, 10 right; cleared in CLEAR
//  l_score       out  3  left rounds won
//  r_score       out  3  right rounds won
//  match_winner  out  2  player_t; non-zero only in DONE
// BEHAVIOUR
//  - All outputs are registered. On reset: state=IDLE, field_reset=1, pull_en=0, round_winner=00,
//    scores=0, match_winner=00, hold counter=0.
//  - left_win  = PLAY & left_edge & L & ~R
//  - right_win = PLAY & right_edge & R & ~L
//  - If L and R are high in the same cycle, neither player wins (the pulls cancel).
//  - If left_edge and right_edge are both high (illegal), no win is detected.
//  - IDLE: field_reset=1, pull_en=0. On start, go to PLAY; next cycle field_reset=0, pull_en=1.
//  - PLAY: on a win, the winner's score increments and round_winner is set on the next clock (latency 1).
//    pull_en drops on that same edge.
//    -> DONE if the new score equals WIN_ROUNDS (match_winner=player), else -> HOLD.
//  - HOLD: pull_en=0. The hold timer loads HOLD_CYCLES-1 on entry and counts down.
//    On reaching 0, go to CLEAR, so HOLD lasts exactly HOLD_CYCLES cycles.
//  - CLEAR: exactly 1 cycle. field_reset=1, round_winner cleared to 00, -> PLAY.
//  - DONE: pull_en=0. Scores and match_winner are held. On start: scores=0, match_winner=00, -> CLEAR.
//  - start is ignored in PLAY, HOLD and CLEAR. L and R are ignored outside PLAY.
//  - Score counters never exceed WIN_ROUNDS; there is no wrap.
//  - Reset asserted mid-HOLD or mid-DONE returns to the reset values immediately (asynchronous).
// STRUCTURE
//  - Shared package tug_pkg holds:
//    typedef enum logic[1:0] player_t {NONE, LEFT, RIGHT};
//    typedef enum logic[2:0] ctrl_state_t {IDLE, PLAY, HOLD, CLEAR, DONE};
//  - One sub-module, hold_timer: parameterised down-counter with load and done.
//    Counter width is $clog2(HOLD_CYCLES+1).
//  - The FSM and score registers live in this module.
// TESTING  (WIN_ROUNDS=3, HOLD_CYCLES=4)
//  1. Reset, then pulse start
//     -> field_reset 1->0 and pull_en=1 one cycle after start; scores 0/0.
//  2. left_edge=1, L pulse
//     -> next cycle l_score=1, round_winner=01, pull_en=0.
//     -> 4 cycles later field_reset=1 for 1 cycle, round_winner=00, then pull_en=1.
//  3. right_edge=1, L and R pulsed together -> no score change, state stays PLAY.
//  4. L pulses while in HOLD, and start pulsed in HOLD -> ignored; the scores and hold timing are unchanged.
//  5. Three right wins -> r_score=3, match_winner=10, pull_en stays 0.
//     Then start -> scores 0/0, match_winner=00, one-cycle field_reset, PLAY.
//  6. Assert reset two cycles into HOLD -> all outputs take their reset values in the same cycle, with no clock needed.

Source files
------------

// File: rtl/tug_pkg.sv
// Shared types for the tug-of-war match controller: player identifiers and controller states.
package tug_pkg;

    typedef enum logic [1:0] {NONE, LEFT, RIGHT} player_t;

    typedef enum logic [2:0] {IDLE, PLAY, HOLD, CLEAR, DONE} ctrl_state_t;

    localparam int SCORE_W = 3;

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that times how long a round result stays on display.
module hold_timer #(
    parameter int HOLD_CYCLES = 4,
    parameter int W           = $clog2(HOLD_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam logic [W-1:0] LOAD_VAL = W'(HOLD_CYCLES - 1);

    logic [W-1:0] count;

    // Load wins over counting so a fresh hold always starts from the full value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/tug_match_controller.sv
// Best-of-N tug-of-war match sequencer: detects round wins, keeps scores, holds and clears the field.
module tug_match_controller
    import tug_pkg::*;
#(
    parameter int WIN_ROUNDS  = 3,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               L,
    input  logic               R,
    input  logic               left_edge,
    input  logic               right_edge,
    output logic               pull_en,
    output logic               field_reset,
    output player_t            round_winner,
    output logic [SCORE_W-1:0] l_score,
    output logic [SCORE_W-1:0] r_score,
    output player_t            match_winner,
    output ctrl_state_t        state
);

    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_ROUNDS);

    logic edges_ok;
    logic left_win;
    logic right_win;
    logic match_end;
    logic timer_load;
    logic timer_done;

    // Both edge lights lit is an impossible field; refuse to award anything from it.
    assign edges_ok   = ~(left_edge & right_edge);
    assign left_win   = (state == PLAY) & edges_ok & left_edge & L & ~R;
    assign right_win  = (state == PLAY) & edges_ok & right_edge & R & ~L;
    assign match_end  = (left_win  & (l_score + SCORE_W'(1) == WIN_VAL)) |
                        (right_win & (r_score + SCORE_W'(1) == WIN_VAL));
    assign timer_load = (left_win | right_win) & ~match_end;

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk  (clk),
        .reset(reset),
        .load (timer_load),
        .en   (state == HOLD),
        .done (timer_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            field_reset  <= 1'b1;
            pull_en      <= 1'b0;
            round_winner <= NONE;
            l_score      <= '0;
            r_score      <= '0;
            match_winner <= NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= PLAY;
                        field_reset <= 1'b0;
                        pull_en     <= 1'b1;
                    end
                end
                PLAY: begin
                    if (left_win || right_win) begin
                        pull_en      <= 1'b0;
                        round_winner <= left_win ? LEFT : RIGHT;
                        if (left_win && l_score < WIN_VAL) l_score <= l_score + SCORE_W'(1);
                        if (right_win && r_score < WIN_VAL) r_score <= r_score + SCORE_W'(1);
                        if (match_end) begin
                            state        <= DONE;
                            match_winner <= left_win ? LEFT : RIGHT;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (timer_done) begin
                        state        <= CLEAR;
                        field_reset  <= 1'b1;
                        round_winner <= NONE;
                    end
                end
                CLEAR: begin
                    state       <= PLAY;
                    field_reset <= 1'b0;
                    pull_en     <= 1'b1;
                end
                DONE: begin
                    if (start) begin
                        state        <= CLEAR;
                        l_score      <= '0;
                        r_score      <= '0;
                        match_winner <= NONE;
                        field_reset  <= 1'b1;
                        round_winner <= NONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tug_match_controller.sv
// Directed bench for tug_match_controller with WIN_ROUNDS=3 and HOLD_CYCLES=4.
module tb_tug_match_controller;
    import tug_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        L = 1'b0;
    logic        R = 1'b0;
    logic        left_edge = 1'b0;
    logic        right_edge = 1'b0;
    logic        pull_en;
    logic        field_reset;
    player_t     round_winner;
    logic [2:0]  l_score;
    logic [2:0]  r_score;
    player_t     match_winner;
    ctrl_state_t state;

    int n_cmp = 0;
    int n_bad = 0;

    tug_match_controller #(
        .WIN_ROUNDS (3),
        .HOLD_CYCLES(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .L           (L),
        .R           (R),
        .left_edge   (left_edge),
        .right_edge  (right_edge),
        .pull_en     (pull_en),
        .field_reset (field_reset),
        .round_winner(round_winner),
        .l_score     (l_score),
        .r_score     (r_score),
        .match_winner(match_winner),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        start = 1'b0; L = 1'b0; R = 1'b0; left_edge = 1'b0; right_edge = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(state), 32'(IDLE));
        check({tag, "_field_reset"}, 32'(field_reset), 32'd1);
        check({tag, "_pull_en"}, 32'(pull_en), 32'd0);
        check({tag, "_round_winner"}, 32'(round_winner), 32'(NONE));
        check({tag, "_l_score"}, 32'(l_score), 32'd0);
        check({tag, "_r_score"}, 32'(r_score), 32'd0);
        check({tag, "_match_winner"}, 32'(match_winner), 32'(NONE));
    endtask

    // One right round won from PLAY, then ride through HOLD (4) and CLEAR (1) back to PLAY.
    task automatic right_round(input int exp_r);
        right_edge = 1'b1; R = 1'b1;
        tick();
        clear_inputs();
        check("rwin_r_score", 32'(r_score), 32'(exp_r));
        check("rwin_round_winner", 32'(round_winner), 32'(RIGHT));
        check("rwin_state", 32'(state), 32'(HOLD));
        repeat (5) tick();
        check("rwin_back_play", 32'(state), 32'(PLAY));
        check("rwin_back_pull_en", 32'(pull_en), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check_reset_values("rst");
        reset = 1'b0;
        tick();
        check("idle_hold_state", 32'(state), 32'(IDLE));

        // 1. Start the match
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_state", 32'(state), 32'(PLAY));
        check("t1_field_reset", 32'(field_reset), 32'd0);
        check("t1_pull_en", 32'(pull_en), 32'd1);
        check("t1_scores", 32'({l_score, r_score}), 32'd0);

        // 2. Left win, plus 4. ignored L/start during HOLD
        left_edge = 1'b1; L = 1'b1;
        tick();
        clear_inputs();
        check("t2_l_score", 32'(l_score), 32'd1);
        check("t2_round_winner", 32'(round_winner), 32'(LEFT));
        check("t2_pull_en", 32'(pull_en), 32'd0);
        check("t2_state", 32'(state), 32'(HOLD));
        left_edge = 1'b1; L = 1'b1; start = 1'b1;
        tick();
        clear_inputs();
        check("t4_l_score", 32'(l_score), 32'd1);
        check("t4_state", 32'(state), 32'(HOLD));
        tick();
        check("t2_hold3_state", 32'(state), 32'(HOLD));
        tick();
        check("t2_hold4_state", 32'(state), 32'(HOLD));
        check("t2_hold4_field_reset", 32'(field_reset), 32'd0);
        start = 1'b1;
        tick();
        check("t2_clear_state", 32'(state), 32'(CLEAR));
        check("t2_clear_field_reset", 32'(field_reset), 32'd1);
        check("t2_clear_round_winner", 32'(round_winner), 32'(NONE));
        check("t2_clear_pull_en", 32'(pull_en), 32'd0);
        tick();
        clear_inputs();
        check("t2_play_state", 32'(state), 32'(PLAY));
        check("t2_play_field_reset", 32'(field_reset), 32'd0);
        check("t2_play_pull_en", 32'(pull_en), 32'd1);

        // 3. Cancelled pulls, illegal edges, pull without edge
        right_edge = 1'b1; L = 1'b1; R = 1'b1;
        tick();
        clear_inputs();
        check("t3_cancel_scores", 32'({l_score, r_score}), 32'({3'd1, 3'd0}));
        check("t3_cancel_state", 32'(state), 32'(PLAY));
        left_edge = 1'b1; right_edge = 1'b1; L = 1'b1;
        tick();
        clear_inputs();
        check("t3_illegal_scores", 32'({l_score, r_score}), 32'({3'd1, 3'd0}));
        check("t3_illegal_state", 32'(state), 32'(PLAY));
        R = 1'b1;
        tick();
        clear_inputs();
        check("t3_noedge_r_score", 32'(r_score), 32'd0);
        check("t3_noedge_state", 32'(state), 32'(PLAY));

        // 5. Three right wins end the match
        right_round(1);
        right_round(2);
        right_edge = 1'b1; R = 1'b1;
        tick();
        clear_inputs();
        check("t5_r_score", 32'(r_score), 32'd3);
        check("t5_l_score", 32'(l_score), 32'd1);
        check("t5_match_winner", 32'(match_winner), 32'(RIGHT));
        check("t5_state", 32'(state), 32'(DONE));
        check("t5_pull_en", 32'(pull_en), 32'd0);
        right_edge = 1'b1; R = 1'b1;
        tick();
        clear_inputs();
        repeat (5) tick();
        check("t5_done_held_state", 32'(state), 32'(DONE));
        check("t5_done_held_r_score", 32'(r_score), 32'd3);
        check("t5_done_pull_en", 32'(pull_en), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_restart_scores", 32'({l_score, r_score}), 32'd0);
        check("t5_restart_match_winner", 32'(match_winner), 32'(NONE));
        check("t5_restart_state", 32'(state), 32'(CLEAR));
        check("t5_restart_field_reset", 32'(field_reset), 32'd1);
        tick();
        check("t5_replay_state", 32'(state), 32'(PLAY));
        check("t5_replay_field_reset", 32'(field_reset), 32'd0);
        check("t5_replay_pull_en", 32'(pull_en), 32'd1);

        // 6. Asynchronous reset two cycles into HOLD
        left_edge = 1'b1; L = 1'b1;
        tick();
        clear_inputs();
        check("t6_l_score", 32'(l_score), 32'd1);
        tick();
        check("t6_pre_state", 32'(state), 32'(HOLD));
        #1;
        reset = 1'b1;
        #1;
        check_reset_values("t6_async");
        tick();
        reset = 1'b0;
        tick();
        check("t6_after_state", 32'(state), 32'(IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
